// File: rtl/bcd_number_parser.sv
// bcd_number_parser: sign + three BCD digits -> saturated WIDTH-bit two's-complement operand via multi-cycle reverse double dabble
module bcd_number_parser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             negative,
  input  logic [3:0]       bcd_hundreds,
  input  logic [3:0]       bcd_tens,
  input  logic [3:0]       bcd_units,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] binary_out,
  output logic             overflow,
  output logic             invalid_digit
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam logic [10:0] MAX_POS = 11'((1 << (WIDTH - 1)) - 1);
  function automatic logic [3:0] fix(input logic [3:0] d);
    return d >= 4'd8 ? d - 4'd3 : d;
  endfunction
  state_t             state_q, state_d;
  logic [21:0]        sr_q, sr_d, sh, step;
  logic [3:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d, bad_q, bad_d, busy_q, busy_d, done_q, done_d;
  logic               ovf_q, ovf_d, inv_q, inv_d, sat;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [9:0]         mag;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    sh      = {1'b0, sr_q[21:1]};
    step    = {fix(sh[21:18]), fix(sh[17:14]), fix(sh[13:10]), sh[9:0]};
    mag     = sr_q[9:0];
    sat     = neg_q ? {1'b0, mag} > MAX_POS + 11'd1 : {1'b0, mag} > MAX_POS;
    case (state_q)
      IDLE: if (start) begin
        neg_d   = negative;
        sr_d    = {bcd_hundreds, bcd_tens, bcd_units, 10'd0};
        cnt_d   = 4'd0;
        busy_d  = 1'b1;
        bad_d   = bcd_hundreds > 4'd9 || bcd_tens > 4'd9 || bcd_units > 4'd9;
        state_d = bad_d ? FINISH : SHIFT;
      end
      SHIFT: begin
        sr_d    = step;
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd9 ? FINISH : SHIFT;
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        inv_d   = bad_q;
        ovf_d   = !bad_q && sat;
        out_d   = bad_q ? '0 :
                  sat   ? (neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                  neg_q ? WIDTH'(-mag) : WIDTH'(mag);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign binary_out    = out_q;
  assign overflow      = ovf_q;
  assign invalid_digit = inv_q;
endmodule

// File: tb/tb_bcd_number_parser.sv
// tb_bcd_number_parser: table, random-vs-model and handshake corner checks for bcd_number_parser
module tb_bcd_number_parser;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, negative = 0;
  logic [3:0] bcd_hundreds = 0, bcd_tens = 0, bcd_units = 0;
  logic busy, done, overflow, invalid_digit;
  logic [W-1:0] binary_out;
  int n_vec = 0, n_fail = 0;
  bcd_number_parser #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .negative(negative),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .busy(busy), .done(done), .binary_out(binary_out),
    .overflow(overflow), .invalid_digit(invalid_digit)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic neg; logic [3:0] h, t, u;
    logic [W-1:0] out; logic ovf, inv;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void model(input logic neg, input int h, input int t, input int u,
                                output logic [W-1:0] out, output logic ovf, output logic inv);
    int m, lim;
    lim = 1 << (W - 1);
    inv = h > 9 || t > 9 || u > 9;
    m = h * 100 + t * 10 + u;
    if (inv) begin out = '0; ovf = 0; end
    else if (!neg) begin ovf = m > lim - 1; out = W'(ovf ? lim - 1 : m); end
    else begin ovf = m > lim; out = W'(ovf ? -lim : -m); end
  endfunction
  task automatic conv(input string name, input logic neg, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] u, input logic [W-1:0] eo, input logic eovf, input logic einv);
    int lat;
    negative = neg; bcd_hundreds = h; bcd_tens = t; bcd_units = u; start = 1;
    @(posedge clk); #1;
    start = 0;
    negative = ~neg; bcd_hundreds = 4'($urandom); bcd_tens = 4'($urandom); bcd_units = 4'($urandom);
    chk({name, " busy"}, busy, 1);
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk({name, " latency"}, lat, einv ? 1 : 11);
    chk({name, " busy at done"}, busy, 0);
    chk({name, " out"}, binary_out, eo);
    chk({name, " ovf"}, overflow, eovf);
    chk({name, " inv"}, invalid_digit, einv);
  endtask
  initial begin
    vec_t tbl[10];
    logic [W-1:0] eo;
    logic eovf, einv;
    int first, second, pulses;
    logic [W-1:0] got;
    tbl[0] = '{0, 0, 4, 2, 8'h2A, 0, 0};
    tbl[1] = '{0, 1, 2, 7, 8'h7F, 0, 0};
    tbl[2] = '{1, 1, 2, 8, 8'h80, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 8'hFF, 0, 0};
    tbl[4] = '{1, 0, 0, 0, 8'h00, 0, 0};
    tbl[5] = '{0, 1, 2, 8, 8'h7F, 1, 0};
    tbl[6] = '{1, 1, 2, 9, 8'h80, 1, 0};
    tbl[7] = '{0, 9, 9, 9, 8'h7F, 1, 0};
    tbl[8] = '{0, 0, 4'hA, 2, 8'h00, 0, 1};
    tbl[9] = '{1, 4'hF, 0, 0, 8'h00, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out", binary_out, 0);
    chk("reset ovf", overflow, 0);
    chk("reset inv", invalid_digit, 0);
    rst_n = 1;
    @(posedge clk); #1;
    foreach (tbl[i])
      conv($sformatf("tbl%0d", i), tbl[i].neg, tbl[i].h, tbl[i].t, tbl[i].u, tbl[i].out, tbl[i].ovf, tbl[i].inv);
    for (int i = 0; i < 40; i++) begin
      logic n;
      logic [3:0] h, t, u;
      n = 1'($urandom);
      h = 4'($urandom_range(0, 11)); t = 4'($urandom_range(0, 11)); u = 4'($urandom_range(0, 11));
      model(n, h, t, u, eo, eovf, einv);
      conv($sformatf("rnd%0d", i), n, h, t, u, eo, eovf, einv);
    end
    // restart attempt mid-conversion must be ignored
    negative = 0; bcd_hundreds = 0; bcd_tens = 4; bcd_units = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    bcd_tens = 9; bcd_units = 9; start = 1;
    @(posedge clk); #1;
    start = 0;
    pulses = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; got = binary_out; end
    end
    chk("restart pulses", pulses, 1);
    chk("restart out", got, 8'h2A);
    // start held high: back-to-back conversions
    negative = 1; bcd_hundreds = 0; bcd_tens = 0; bcd_units = 5; start = 1;
    first = -1; second = -1;
    for (int i = 0; i < 40 && second < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = i; else begin second = i; start = 0; end
      end
    end
    start = 0;
    chk("b2b gap", second - first, 12);
    chk("b2b out", binary_out, 8'hFB);
    // reset in the middle of a conversion
    negative = 0; bcd_hundreds = 0; bcd_tens = 4; bcd_units = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrst out", binary_out, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midrst no done", pulses, 0);
    conv("post rst +100", 0, 1, 0, 0, 8'h64, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
